alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 175 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - three-state sequencer driving an external ALU over a small register file
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   instr_valid / instr_ready  instruction handshake (ready only while idle)
//   instr_op/rd/rs1/rs2        operation code and register indices
//   instr_imm_en, instr_imm    select and value of immediate B operand
//   alu_a, alu_b, alu_sel      registered operands and op select to the ALU
//   alu_out, alu_carry         ALU result and A+B carry
//   done                       one-cycle pulse in the write-back cycle
//   flag_z, flag_c, flag_dz    zero, add-carry and divide-by-zero flags
//   dbg_addr, dbg_data         combinational register-file read port
module alu_sequencer #(
    parameter int DW   = 8,
    parameter int NREG = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [3:0]    instr_op,
    input  logic [1:0]    instr_rd,
    input  logic [1:0]    instr_rs1,
    input  logic [1:0]    instr_rs2,
    input  logic          instr_imm_en,
    input  logic [DW-1:0] instr_imm,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_sel,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_carry,
    output logic          done,
    output logic          flag_z,
    output logic          flag_c,
    output logic          flag_dz,
    input  logic [1:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_DIV = 4'b0011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];
    logic [DW-1:0] alu_a_q, alu_a_d;
    logic [DW-1:0] alu_b_q, alu_b_d;
    logic [3:0]    alu_sel_q, alu_sel_d;
    logic [1:0]    rd_q, rd_d;
    logic [DW-1:0] res_q, res_d;
    logic          carry_q, carry_d;
    logic          flag_z_q, flag_z_d;
    logic          flag_c_q, flag_c_d;
    logic          flag_dz_q, flag_dz_d;
    logic          accept;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        instr_ready = 1'b0;
        done        = 1'b0;
        case (state_q)
            S_IDLE:  instr_ready = 1'b1;
            S_WB:    done        = 1'b1;
            default: ;
        endcase
    end

    assign accept = instr_valid && instr_ready;

    // Datapath next values. alu_sel_q doubles as the latched opcode, since it
    // is only reloaded on the next accept.
    always_comb begin
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        rd_d      = rd_q;
        res_d     = res_q;
        carry_d   = carry_q;
        flag_z_d  = flag_z_q;
        flag_c_d  = flag_c_q;
        flag_dz_d = flag_dz_q;
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end

        if (accept) begin
            alu_a_d   = regs_q[instr_rs1];
            alu_b_d   = instr_imm_en ? instr_imm : regs_q[instr_rs2];
            alu_sel_d = instr_op;
            rd_d      = instr_rd;
        end

        if (state_q == S_EXEC) begin
            res_d   = alu_out;
            carry_d = alu_carry;
        end

        if (state_q == S_WB) begin
            if (alu_sel_q == OP_DIV && alu_b_q == '0) begin
                flag_dz_d = 1'b1;
            end else if (alu_sel_q[3:1] != 3'b111) begin
                // 1110/1111 fall through untouched as NOPs
                regs_d[rd_q] = res_q;
                flag_z_d     = (res_q == '0);
                flag_c_d     = (alu_sel_q == OP_ADD) && carry_q;
                flag_dz_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
            rd_q      <= '0;
            res_q     <= '0;
            carry_q   <= 1'b0;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
            flag_dz_q <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
            rd_q      <= rd_d;
            res_q     <= res_d;
            carry_q   <= carry_d;
            flag_z_q  <= flag_z_d;
            flag_c_q  <= flag_c_d;
            flag_dz_q <= flag_dz_d;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_sel  = alu_sel_q;
    assign flag_z   = flag_z_q;
    assign flag_c   = flag_c_q;
    assign flag_dz  = flag_dz_q;
    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer with a behavioural ALU
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [3:0] instr_op = '0;
    logic [1:0] instr_rd = '0;
    logic [1:0] instr_rs1 = '0;
    logic [1:0] instr_rs2 = '0;
    logic       instr_imm_en = 1'b0;
    logic [7:0] instr_imm = '0;
    logic [7:0] alu_a, alu_b;
    logic [3:0] alu_sel;
    logic [7:0] alu_out;
    logic       alu_carry;
    logic       done;
    logic       flag_z, flag_c, flag_dz;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    logic       mon_active = 1'b0;
    logic [1:0] mon_addr = '0;
    logic [1:0] main_addr = '0;
    assign dbg_addr = mon_active ? mon_addr : main_addr;

    int n_chk  = 0;
    int n_fail = 0;
    int done_cnt = 0;

    typedef struct packed {
        logic [3:0][7:0] regs;
        logic            z;
        logic            c;
        logic            dz;
    } snap_t;

    snap_t           sb[$];
    logic [3:0][7:0] exp_regs = '0;

    alu_sequencer #(.DW(8), .NREG(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_rd     (instr_rd),
        .instr_rs1    (instr_rs1),
        .instr_rs2    (instr_rs2),
        .instr_imm_en (instr_imm_en),
        .instr_imm    (instr_imm),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_sel      (alu_sel),
        .alu_out      (alu_out),
        .alu_carry    (alu_carry),
        .done         (done),
        .flag_z       (flag_z),
        .flag_c       (flag_c),
        .flag_dz      (flag_dz),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: 0 add, 1 sub, 3 div, 4 mul (truncated), others xor
    logic [8:0]  sum9;
    logic [15:0] prod;
    always_comb begin
        sum9 = {1'b0, alu_a} + {1'b0, alu_b};
        prod = alu_a * alu_b;
        alu_carry = sum9[8];
        case (alu_sel)
            4'h0:    alu_out = sum9[7:0];
            4'h1:    alu_out = alu_a - alu_b;
            4'h3:    alu_out = (alu_b == 8'h00) ? 8'hFF : alu_a / alu_b;
            4'h4:    alu_out = prod[7:0];
            default: alu_out = alu_a ^ alu_b;
        endcase
    end

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: the cycle after each done pulse, compare the whole register file and flags
    initial begin
        snap_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                @(negedge clk);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    mon_active = 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        mon_addr = i[1:0];
                        #1;
                        chk($sformatf("sb_reg%0d", i), {24'h0, dbg_data}, {24'h0, e.regs[i]});
                    end
                    chk("sb_flag_z", {31'h0, flag_z}, {31'h0, e.z});
                    chk("sb_flag_c", {31'h0, flag_c}, {31'h0, e.c});
                    chk("sb_flag_dz", {31'h0, flag_dz}, {31'h0, e.dz});
                    mon_active = 1'b0;
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", {31'h0, instr_ready}, 32'h1);
    endtask

    task automatic drive(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic ie, input logic [7:0] imm);
        instr_op     = op;
        instr_rd     = rd;
        instr_rs1    = rs1;
        instr_rs2    = rs2;
        instr_imm_en = ie;
        instr_imm    = imm;
        instr_valid  = 1'b1;
    endtask

    task automatic push(input logic wr, input logic [1:0] rd, input logic [7:0] val,
                        input logic ez, input logic ec, input logic edz);
        snap_t s;
        if (wr) exp_regs[rd] = val;
        s.regs = exp_regs;
        s.z    = ez;
        s.c    = ec;
        s.dz   = edz;
        sb.push_back(s);
    endtask

    task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic ie, input logic [7:0] imm,
                         input logic wr, input logic [7:0] val,
                         input logic ez, input logic ec, input logic edz);
        wait_ready();
        drive(op, rd, rs1, rs2, ie, imm);
        push(wr, rd, val, ez, ec, edz);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        chk("done_exec", {31'h0, done}, 32'h0);
        chk("ready_exec", {31'h0, instr_ready}, 32'h0);
        @(negedge clk);
        chk("done_wb", {31'h0, done}, 32'h1);
        @(negedge clk);
        chk("done_idle", {31'h0, done}, 32'h0);
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            main_addr = i[1:0];
            #1;
            chk($sformatf("%s_reg%0d", tag, i), {24'h0, dbg_data}, {24'h0, exp_regs[i]});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_alu_a"}, {24'h0, alu_a}, 32'h0);
        chk({tag, "_alu_b"}, {24'h0, alu_b}, 32'h0);
        chk({tag, "_alu_sel"}, {28'h0, alu_sel}, 32'h0);
        chk({tag, "_done"}, {31'h0, done}, 32'h0);
        chk({tag, "_flags"}, {29'h0, flag_z, flag_c, flag_dz}, 32'h0);
    endtask

    initial begin
        int         d0;
        logic [5:0] rdy_pat;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'h0, instr_ready}, 32'h1);
        check_reset_outputs("rst");
        check_all_regs("rst");

        //     op     rd  rs1 rs2 ie  imm     wr  val    z  c  dz
        issue(4'h0, 1, 0, 0, 1, 8'h25, 1, 8'h25, 0, 0, 0);
        issue(4'h0, 1, 0, 0, 1, 8'hF0, 1, 8'hF0, 0, 0, 0);
        issue(4'h0, 2, 1, 0, 1, 8'h20, 1, 8'h10, 0, 1, 0);
        issue(4'h1, 3, 2, 0, 1, 8'h10, 1, 8'h00, 1, 0, 0);
        issue(4'h1, 0, 1, 0, 1, 8'hF0, 1, 8'h00, 1, 0, 0);
        issue(4'h0, 1, 1, 0, 1, 8'h35, 1, 8'h25, 0, 1, 0);
        issue(4'h3, 1, 1, 0, 1, 8'h00, 0, 8'h00, 0, 1, 1);
        issue(4'hE, 1, 2, 0, 1, 8'h00, 0, 8'h00, 0, 1, 1);
        issue(4'hF, 1, 2, 0, 1, 8'h00, 0, 8'h00, 0, 1, 1);
        issue(4'h3, 0, 1, 2, 0, 8'h01, 1, 8'h02, 0, 0, 0);
        issue(4'h4, 0, 2, 0, 1, 8'h30, 1, 8'h00, 1, 0, 0);

        // Held valid: same instruction accepted twice, rd == rs1 uses old value
        wait_ready();
        d0 = done_cnt;
        drive(4'h0, 3, 3, 0, 1, 8'h05);
        push(1, 3, 8'h05, 0, 0, 0);
        push(1, 3, 8'h0A, 0, 0, 0);
        rdy_pat = 6'b100100;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("held_ready%0d", i), {31'h0, instr_ready}, {31'h0, rdy_pat[i]});
        end
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_done_count", done_cnt - d0, 32'd2);

        // Reset during EXEC aborts the write and the done pulse
        wait_ready();
        drive(4'h0, 2, 0, 0, 1, 8'h77);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        chk("abort_in_exec", {31'h0, instr_ready}, 32'h0);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        exp_regs = '0;
        check_reset_outputs("abort");
        check_all_regs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", {31'h0, instr_ready}, 32'h1);
        repeat (3) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 32'd0);
        check_all_regs("post_abort");

        chk("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
